// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: four-way round-robin lamp sequencer with car skipping and emergency pre-empt
module traffic_phase_fsm #(
    parameter int GREEN_SEC  = 10,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_1hz,
    input  logic [3:0]       car_present,
    input  logic             emerg,
    output logic [11:0]      lights,
    output logic [1:0]       active_dir,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] sec_left
);
    typedef enum logic [1:0] {ALLRED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} state_t;
    state_t           state, state_n;
    logic [1:0]       dir_n, pick, idx;
    logic [CNT_W-1:0] sec_n;
    logic [11:0]      lights_n;
    logic             clk_1hz_d, hi_at_rst, tick, last;
    // hi_at_rst masks the level that was already high when reset released
    assign tick  = clk_1hz & ~clk_1hz_d & ~hi_at_rst;
    assign last  = sec_left == CNT_W'(1);
    assign phase = state;
    // first waiting approach after the current one; plain round-robin if none wait
    always_comb begin
        pick = active_dir + 2'd1;
        idx  = '0;
        for (int i = 4; i >= 1; i--) begin
            idx = active_dir + 2'(i);
            if (car_present[idx]) pick = idx;
        end
    end
    // next state, countdown and lamp decode
    always_comb begin
        state_n = state;
        dir_n   = active_dir;
        sec_n   = sec_left;
        if (state == GREEN && emerg) begin
            state_n = YELLOW;
            sec_n   = CNT_W'(YELLOW_SEC);
        end else if (tick && !last) begin
            sec_n = sec_left - CNT_W'(1);
        end else if (tick) begin
            unique case (state)
                GREEN: begin
                    state_n = YELLOW;
                    sec_n   = CNT_W'(YELLOW_SEC);
                end
                YELLOW: begin
                    state_n = ALLRED;
                    sec_n   = CNT_W'(ALLRED_SEC);
                end
                default: begin
                    state_n = emerg ? ALLRED : GREEN;
                    sec_n   = emerg ? CNT_W'(ALLRED_SEC) : CNT_W'(GREEN_SEC);
                    dir_n   = emerg ? active_dir : pick;
                end
            endcase
        end
        lights_n = {4{3'b100}};
        if (state_n != ALLRED) lights_n[3*dir_n +: 3] = (state_n == GREEN) ? 3'b001 : 3'b010;
    end
    // state register; reset forces all-red with the clearance count loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ALLRED;
            active_dir <= 2'd3;
            sec_left   <= CNT_W'(ALLRED_SEC);
            lights     <= 12'b100_100_100_100;
            clk_1hz_d  <= 1'b0;
            hi_at_rst  <= clk_1hz;
        end else begin
            state      <= state_n;
            active_dir <= dir_n;
            sec_left   <= sec_n;
            lights     <= lights_n;
            clk_1hz_d  <= clk_1hz;
            hi_at_rst  <= hi_at_rst & clk_1hz;
        end
    end
endmodule

// File: tb/tb_traffic_phase_fsm.sv
// tb_traffic_phase_fsm: table vectors, hand sequences and randomized run against a reference model
module tb_traffic_phase_fsm;
    logic        clk = 0, rst = 0, clk_1hz = 0, emerg = 0;
    logic [3:0]  car_present = 0;
    logic [11:0] lights;
    logic [1:0]  active_dir, phase;
    logic [7:0]  sec_left;
    int          errs = 0, checks = 0;
    int          m_ph, m_dir, m_sec;
    bit          m_prev;

    localparam logic [11:0] AR = 12'b100_100_100_100, NG = 12'b100_100_100_001,
        NY = 12'b100_100_100_010, EG = 12'b100_100_001_100, EY = 12'b100_100_010_100,
        SG = 12'b100_001_100_100, SY = 12'b100_010_100_100, WG = 12'b001_100_100_100;

    traffic_phase_fsm dut (.clk(clk), .rst(rst), .clk_1hz(clk_1hz), .car_present(car_present),
        .emerg(emerg), .lights(lights), .active_dir(active_dir), .phase(phase), .sec_left(sec_left));

    always #5 clk = ~clk;

    typedef struct {
        int         ticks;
        logic [3:0] car;
        logic       em;
        logic [1:0] ph;
        logic [1:0] dir;
        logic [7:0] sec;
        logic [11:0] lt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(int t, logic [3:0] c, logic e, logic [1:0] p, logic [1:0] d,
                                logic [7:0] s, logic [11:0] l);
        vec_t v;
        v.ticks = t; v.car = c; v.em = e; v.ph = p; v.dir = d; v.sec = s; v.lt = l;
        tbl.push_back(v);
    endfunction

    function automatic logic [11:0] lamp(int p, int d);
        logic [11:0] r;
        for (int f = 0; f < 4; f++)
            r[f*3 +: 3] = (f != d || p == 0) ? 3'b100 : (p == 1 ? 3'b001 : 3'b010);
        return r;
    endfunction

    function automatic int next_dir(int d, logic [3:0] c);
        for (int k = 1; k <= 4; k++)
            if (c[(d + k) % 4]) return (d + k) % 4;
        return (d + 1) % 4;
    endfunction

    // reference: one clk edge of the controller described in seconds and phases
    task automatic model_edge();
        bit t;
        t = clk_1hz && !m_prev;
        m_prev = clk_1hz;
        if (rst) begin
            m_ph = 0; m_dir = 3; m_sec = 1;
        end else if (m_ph == 1 && emerg) begin
            m_ph = 2; m_sec = 3;
        end else if (t && m_sec > 1) begin
            m_sec--;
        end else if (t) begin
            if (m_ph == 1) begin m_ph = 2; m_sec = 3; end
            else if (m_ph == 2) begin m_ph = 0; m_sec = 1; end
            else if (emerg) m_sec = 1;
            else begin m_dir = next_dir(m_dir, car_present); m_ph = 1; m_sec = 10; end
        end
    endtask

    task automatic cmp(string nm, logic [1:0] p, logic [1:0] d, logic [7:0] s, logic [11:0] l);
        checks++;
        if (phase !== p || active_dir !== d || sec_left !== s || lights !== l) begin
            errs++;
            $display("FAIL %s: got phase=%0d dir=%0d sec=%0d lights=%b, want phase=%0d dir=%0d sec=%0d lights=%b",
                     nm, phase, active_dir, sec_left, lights, p, d, s, l);
        end
    endtask

    task automatic invariants();
        int nr;
        nr = 0;
        for (int f = 0; f < 4; f++) if (lights[f*3 +: 3] != 3'b100) nr++;
        checks += 3;
        if (nr > 1) begin errs++; $display("FAIL one_non_red: got %0d non-red fields, want <=1", nr); end
        if (sec_left < 1 || sec_left > 10) begin errs++; $display("FAIL sec_range: got %0d, want 1..10", sec_left); end
        if (phase == 2'd3) begin errs++; $display("FAIL phase_valid: got 3, want 0..2"); end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cmp("model", 2'(m_ph), 2'(m_dir), 8'(m_sec), lamp(m_ph, m_dir));
        invariants();
    endtask

    task automatic tick();
        clk_1hz = 1; step();
        clk_1hz = 0; step();
    endtask

    task automatic do_reset();
        rst = 1; clk_1hz = 0; step();
        rst = 0;
    endtask

    initial begin
        // 1: all approaches waiting, full round robin
        add(-1, 4'hf, 0, 0, 3, 1, AR);
        add(1, 4'hf, 0, 1, 0, 10, NG);  add(10, 4'hf, 0, 2, 0, 3, NY);
        add(3, 4'hf, 0, 0, 0, 1, AR);   add(1, 4'hf, 0, 1, 1, 10, EG);
        add(14, 4'hf, 0, 1, 2, 10, SG); add(14, 4'hf, 0, 1, 3, 10, WG);
        add(14, 4'hf, 0, 1, 0, 10, NG);
        // 2: south only, re-selected every cycle
        add(-1, 4'b0100, 0, 0, 3, 1, AR);
        add(1, 4'b0100, 0, 1, 2, 10, SG); add(14, 4'b0100, 0, 1, 2, 10, SG);
        add(14, 4'b0100, 0, 1, 2, 10, SG);
        // 3: nobody waiting, plain round robin with full countdowns
        add(-1, 4'h0, 0, 0, 3, 1, AR);
        add(1, 4'h0, 0, 1, 0, 10, NG); add(9, 4'h0, 0, 1, 0, 1, NG);
        add(1, 4'h0, 0, 2, 0, 3, NY);  add(2, 4'h0, 0, 2, 0, 1, NY);
        add(1, 4'h0, 0, 0, 0, 1, AR);  add(1, 4'h0, 0, 1, 1, 10, EG);
        add(14, 4'h0, 0, 1, 2, 10, SG); add(14, 4'h0, 0, 1, 3, 10, WG);
        add(14, 4'h0, 0, 1, 0, 10, NG);
        // 4: emergency mid-second, hold in all-red, then emergency on a tick edge
        add(-1, 4'hf, 0, 0, 3, 1, AR);
        add(1, 4'hf, 0, 1, 0, 10, NG); add(3, 4'hf, 0, 1, 0, 7, NG);
        add(0, 4'hf, 1, 2, 0, 3, NY);  add(3, 4'hf, 1, 0, 0, 1, AR);
        add(2, 4'hf, 1, 0, 0, 1, AR);  add(1, 4'hf, 0, 1, 1, 10, EG);
        add(1, 4'hf, 1, 2, 1, 3, EY);  add(3, 4'hf, 0, 0, 1, 1, AR);
        add(1, 4'hf, 0, 1, 2, 10, SG);
        // 5 prelude: reach south yellow
        add(-1, 4'hf, 0, 0, 3, 1, AR);
        add(1, 4'hf, 0, 1, 0, 10, NG); add(14, 4'hf, 0, 1, 1, 10, EG);
        add(14, 4'hf, 0, 1, 2, 10, SG); add(10, 4'hf, 0, 2, 2, 3, SY);

        foreach (tbl[i]) begin
            car_present = tbl[i].car;
            emerg = tbl[i].em;
            if (tbl[i].ticks < 0) do_reset();
            else if (tbl[i].ticks == 0) step();
            else repeat (tbl[i].ticks) tick();
            cmp($sformatf("vec%0d", i), tbl[i].ph, tbl[i].dir, tbl[i].sec, tbl[i].lt);
        end

        // 5: reset coincident with a tick during south yellow, clk_1hz held high through release
        clk_1hz = 1; rst = 1; step();
        cmp("rst_mid", 2'd0, 2'd3, 8'd1, AR);
        rst = 0; step(); step();
        cmp("no_tick_after_rst", 2'd0, 2'd3, 8'd1, AR);
        clk_1hz = 0; step();
        clk_1hz = 1; step();
        cmp("first_tick_after_rst", 2'd1, 2'd0, 8'd10, NG);
        clk_1hz = 0; step();

        // 6: random sensors and emergencies over 2000 seconds
        do_reset();
        for (int s = 0; s < 2000; s++) begin
            car_present = 4'($urandom);
            if ($urandom_range(0, 9) == 0) emerg = ~emerg;
            clk_1hz = 1;
            repeat ($urandom_range(1, 3)) begin
                if ($urandom_range(0, 19) == 0) emerg = ~emerg;
                step();
            end
            clk_1hz = 0;
            repeat ($urandom_range(1, 3)) begin
                if ($urandom_range(0, 19) == 0) emerg = ~emerg;
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/traffic_phase_fsm.md
Name: traffic_phase_fsm

Overview:
- Four-way intersection controller that sits directly downstream of the clock divider. It consumes the divider's 1 Hz square wave, which is synchronous to clk.
- Sequences green, then yellow, then all-red through the North, East, South and West approaches in round-robin order. Approaches with no waiting car are skipped, and an emergency input pre-empts the sequence.
- Drives the 12 lamp outputs, plus a seconds-remaining count for the downstream display stage.

Parameters:
- GREEN_SEC, 10, green duration in seconds (>=1)
- YELLOW_SEC, 3, yellow duration in seconds (>=1)
- ALLRED_SEC, 1, all-red clearance duration in seconds (>=1)
- CNT_W, 8, width of sec_left; every duration must fit in CNT_W bits

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- clk_1hz  in  1  1 Hz square wave from the divider, synchronous to clk
- car_present  in  4  per-approach vehicle sensor, bit0=N, bit1=E, bit2=S, bit3=W
- emerg  in  1  emergency pre-empt, level, sampled on every clk edge
- lights  out  12  lamps {W,S,E,N}; each 3-bit field is {R,Y,G}; N=lights[2:0]
- active_dir  out  2  approach owning the current or last green (0=N, 1=E, 2=S, 3=W)
- phase  out  2  0=ALLRED, 1=GREEN, 2=YELLOW (3 is never driven)
- sec_left  out  CNT_W  seconds remaining in the current phase

Behaviour:
- Everything is registered and updates only on posedge clk. rst has priority over all other inputs.
- Reset values:
  - state = ALLRED
  - lights = 12'b100_100_100_100
  - active_dir = 3
  - phase = 0
  - sec_left = ALLRED_SEC
  - clk_1hz_d = 0
- Tick generation:
  - clk_1hz_d is a register copy of clk_1hz.
  - tick = clk_1hz & ~clk_1hz_d, i.e. exactly one clk cycle per rising edge of clk_1hz.
  - A clk_1hz that is already high as reset releases produces no tick until its next rising edge.
- Countdown:
  - On a tick with sec_left > 1: sec_left decrements by 1.
  - On a tick with sec_left == 1: the phase transition happens at that same edge, and sec_left loads the new phase's duration.
  - sec_left never reads 0.
- State transitions:
  - GREEN -> YELLOW, loads YELLOW_SEC; active_dir unchanged.
  - YELLOW -> ALLRED, loads ALLRED_SEC.
  - ALLRED, emerg = 0 -> GREEN, loads GREEN_SEC; active_dir <= next_dir.
  - ALLRED, emerg = 1 -> stays ALLRED, reloads ALLRED_SEC; active_dir unchanged.
- next_dir:
  - The first approach in the order active_dir+1, +2, +3, +0 (mod 4) whose car_present bit is 1.
  - If car_present == 0, next_dir = active_dir+1 (plain round-robin).
  - car_present is sampled at the transition edge only.
  - The current approach is re-selected only when it is the sole approach with a waiting car.
- Emergency pre-empt:
  - GREEN with emerg = 1 on any edge, tick or not: go to YELLOW and load YELLOW_SEC immediately.
  - A tick on the same edge is ignored; emerg wins.
  - In YELLOW, emerg has no effect; the yellow runs its full duration.
  - In ALLRED, emerg holds the controller as described above.
- Lamp decode (registered together with the state):
  - Only the active_dir field shows G in GREEN or Y in YELLOW.
  - Every other field shows R.
  - In ALLRED all four fields show R.
  - Safety invariant: at most one field is non-red at any time.
- A mid-operation rst returns all outputs to their reset values on the next edge, regardless of state or of a coincident tick.

Test Plan:
1. Reset, car_present=4'b1111, emerg=0, run 1 Hz ticks. Required:
   - The 1st tick gives N GREEN, sec_left=10, lights=12'b100_100_100_001.
   - 10 ticks later: N YELLOW, sec_left=3.
   - 3 ticks later: ALLRED, sec_left=1.
   - The next tick gives E GREEN. Full cycle N, E, S, W, N confirmed.
2. car_present=4'b0100 (S only), starting from reset. Required:
   - Green goes to S (active_dir=2) and then S again on every cycle.
   - E, N and W never show G or Y.
3. car_present=0. Required: plain round-robin N, E, S, W. Per cycle, sec_left runs 10..1, then 3..1, then 1.
4. N GREEN at sec_left=7; assert emerg mid-second, with no tick. Required:
   - The next edge gives YELLOW, sec_left=3.
   - Holding emerg keeps the controller in ALLRED, with lights all red and sec_left reloaded to 1 on every tick.
   - Releasing emerg: the next tick gives E GREEN.
   - Repeat with emerg rising on the tick edge: YELLOW, sec_left=3, with no decrement.
5. Assert rst during S YELLOW, coincident with a tick. Required: the next edge shows all reset values. Holding clk_1hz high through the reset release produces no tick until its next rising edge.
6. Random car_present and emerg over 2000 simulated seconds. Required:
   - The at-most-one-non-red invariant always holds.
   - sec_left stays within 1..GREEN_SEC.
   - phase is never 3.
